// File: rtl/m4_mem_pkg.sv
// Shared definitions for the M4 work-SRAM controllers: address/data widths,
// control-state encoding and the default SRAM read latency.
package m4_mem_pkg;

  localparam int M4_AW      = 19;            // word address width
  localparam int M4_BANK_BIT = M4_AW;        // bank select sits above the word address
  localparam int M4_FULL_AW = M4_AW + 1;     // {bank, word}
  localparam int M4_DW      = 32;
  localparam int M4_LEN_W   = 21;
  localparam int M4_RD_LAT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } m4_state_e;

  typedef logic [M4_FULL_AW-1:0] m4_addr_t;

endpackage

// File: rtl/m4_mem_rctrl_xt_if.sv
// Job control, SRAM read port and output stream of the M4 read controller.
interface m4_mem_rctrl_xt_if;
  import m4_mem_pkg::*;

  logic                m4_cmd_cycle_stp;
  logic                m4_cmd_cycle;
  logic                rd_start;
  m4_addr_t            rd_base;
  logic [M4_LEN_W-1:0] rd_len;
  logic                rd_abort;
  logic [M4_DW-1:0]    rdata;
  logic [M4_AW-1:0]    rad;
  logic                rd_bank1;
  logic                re;
  logic [3:0]          dqm;
  logic                rd_valid;
  logic [M4_DW-1:0]    rd_data;
  logic                rd_ready;
  logic                rd_busy;
  logic                rd_done;

  modport slave (
    input  m4_cmd_cycle_stp, m4_cmd_cycle, rd_start, rd_base, rd_len, rd_abort,
           rdata, rd_ready,
    output rad, rd_bank1, re, dqm, rd_valid, rd_data, rd_busy, rd_done
  );

  modport master (
    output m4_cmd_cycle_stp, m4_cmd_cycle, rd_start, rd_base, rd_len, rd_abort,
           rdata, rd_ready,
    input  rad, rd_bank1, re, dqm, rd_valid, rd_data, rd_busy, rd_done
  );

endinterface

// File: rtl/m4_rd_fifo.sv
// Small synchronous FIFO for captured read data; flush empties it in one cycle.
module m4_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by the pointers and the
  // head is forced to zero while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

  assign valid = (cnt != '0);
  assign rdata = valid ? mem[rptr] : '0;
  assign count = cnt;

endmodule

// File: rtl/m4_mem_rctrl_xt.sv
// M4 work-SRAM read controller: issues one read per owned command slot and
// streams captured words out through a credit-limited FIFO.
module m4_mem_rctrl_xt
  import m4_mem_pkg::*;
#(
  parameter int RD_LAT     = M4_RD_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              xrst,
  m4_mem_rctrl_xt_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  m4_state_e           state_q, state_d;
  m4_addr_t            addr_q, addr_d;
  logic [M4_LEN_W-1:0] rem_q, rem_d;
  logic [RD_LAT-1:0]   pipe_q;
  logic                re_q, done_q, done_d;
  logic [M4_AW-1:0]    rad_q;
  logic                bank_q;
  logic [CW-1:0]       fifo_count;
  logic                fifo_valid, pop, issue, inflight_zero;
  logic [7:0]          used;

  // Credit counts every word already committed: FIFO contents, the read
  // presented this cycle and every read still travelling through the pipe.
  always_comb begin
    used = 8'(fifo_count) + 8'(re_q);
    for (int i = 0; i < RD_LAT; i++) used = used + 8'(pipe_q[i]);
  end

  assign inflight_zero = !re_q && (pipe_q == '0);
  assign pop           = fifo_valid && bus.rd_ready;
  assign issue         = bus.m4_cmd_cycle_stp && bus.m4_cmd_cycle && (state_q == ST_RUN)
                      && (rem_q != '0) && (used < 8'(FIFO_DEPTH)) && !bus.rd_abort;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (bus.rd_abort) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rd_start) begin
            if (bus.rd_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RUN;
              addr_d  = bus.rd_base;
              rem_d   = bus.rd_len;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr_d = addr_q + m4_addr_t'(1);
            rem_d  = rem_q - M4_LEN_W'(1);
            if (rem_q == M4_LEN_W'(1)) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (inflight_zero && (fifo_count == CW'(1)) && pop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      pipe_q  <= '0;
      re_q    <= 1'b0;
      done_q  <= 1'b0;
      rad_q   <= '0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      re_q    <= issue;
      if (issue) {bank_q, rad_q} <= addr_q;
      if (bus.rd_abort) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= re_q;
        for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  m4_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(M4_DW)) u_fifo (
    .clk   (clk),
    .xrst  (xrst),
    .flush (bus.rd_abort),
    .push  (pipe_q[RD_LAT-1]),
    .wdata (bus.rdata),
    .pop   (pop),
    .rdata (bus.rd_data),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign bus.rad      = rad_q;
  assign bus.rd_bank1 = bank_q;
  assign bus.re       = re_q;
  assign bus.dqm      = 4'd0;
  assign bus.rd_valid = fifo_valid;
  assign bus.rd_busy  = (state_q != ST_IDLE);
  assign bus.rd_done  = done_q;

endmodule

// File: tb/tb_m4_mem_rctrl_xt.sv
// Self-checking bench for m4_mem_rctrl_xt: SRAM model, slot generator and a
// scoreboard of expected words checked at every output handshake.
module tb_m4_mem_rctrl_xt;
  import m4_mem_pkg::*;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;

  logic clk  = 1'b0;
  logic xrst = 1'b0;
  always #5 clk = ~clk;

  m4_mem_rctrl_xt_if bus();

  m4_mem_rctrl_xt #(.RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus.slave)
  );

  typedef struct {int due; logic [31:0] data;} rd_t;

  int tests = 0, fails = 0;
  int cyc = 0;
  int issue_cnt = 0, pop_cnt = 0, done_cnt = 0, done_cyc = -1, last_hs_cyc = -1;
  bit lat_check = 0;
  int stp_per = 4;
  bit gate_alt = 0;
  bit cmd_level = 1;
  m4_addr_t    addr_log[$];
  logic [31:0] exp_q[$];
  int          exp_cyc[$];
  rd_t         sram_q[$];

  function automatic logic [31:0] data_of(m4_addr_t a);
    return {12'hA5C, a};
  endfunction

  // Cycle counter and SRAM: data for a read seen in cycle c is presented in c+RD_LAT.
  initial begin
    bus.rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sram_q.size() > 0 && sram_q[0].due < cyc) void'(sram_q.pop_front());
      if (sram_q.size() > 0 && sram_q[0].due == cyc) begin
        bus.rdata = sram_q[0].data;
        void'(sram_q.pop_front());
      end else begin
        bus.rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Command-slot generator; with gate_alt every other slot belongs to someone else.
  initial begin
    int ph;
    bit slot_cmd;
    ph = 0;
    slot_cmd = 1'b1;
    bus.m4_cmd_cycle_stp = 1'b0;
    bus.m4_cmd_cycle     = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ph >= stp_per - 1) begin
        ph = 0;
        bus.m4_cmd_cycle_stp = 1'b1;
        slot_cmd = gate_alt ? ~slot_cmd : cmd_level;
        bus.m4_cmd_cycle = slot_cmd;
      end else begin
        ph++;
        bus.m4_cmd_cycle_stp = 1'b0;
      end
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (xrst) begin
        if (bus.re) begin
          m4_addr_t a;
          a = {bus.rd_bank1, bus.rad};
          issue_cnt++;
          addr_log.push_back(a);
          exp_q.push_back(data_of(a));
          exp_cyc.push_back(cyc);
          sram_q.push_back('{due: cyc + RD_LAT, data: data_of(a)});
          tests++;
          if (bus.m4_cmd_cycle !== 1'b1) begin
            fails++;
            $display("FAIL slot_owner: re in slot with m4_cmd_cycle=%b, required 1", bus.m4_cmd_cycle);
          end
        end
        if (bus.rd_valid && bus.rd_ready) begin
          pop_cnt++;
          last_hs_cyc = cyc;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rd_data: unexpected word %h, none outstanding", bus.rd_data);
          end else begin
            logic [31:0] e;
            int ic;
            e  = exp_q.pop_front();
            ic = exp_cyc.pop_front();
            if (bus.rd_data !== e) begin
              fails++;
              $display("FAIL rd_data: got %h required %h", bus.rd_data, e);
            end
            if (lat_check) begin
              tests++;
              if (cyc != ic + RD_LAT + 1) begin
                fails++;
                $display("FAIL latency: handshake cycle %0d required %0d", cyc, ic + RD_LAT + 1);
              end
            end
          end
        end
        if (bus.rd_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_stats();
    issue_cnt = 0;
    pop_cnt   = 0;
    addr_log.delete();
  endtask

  task automatic start_job(m4_addr_t base, logic [20:0] len);
    bus.rd_base  = base;
    bus.rd_len   = len;
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
  endtask

  task automatic wait_done(int base_cnt, int budget, string name);
    int n;
    n = 0;
    while (done_cnt == base_cnt && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (done_cnt == base_cnt) begin
      fails++;
      $display("FAIL %s_done_timeout: no rd_done within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    tick(3);
    tests += 8;
    if (bus.rad !== '0)      begin fails++; $display("FAIL reset_rad: got %h required 0", bus.rad); end
    if (bus.rd_bank1 !== 0)  begin fails++; $display("FAIL reset_bank: got %b required 0", bus.rd_bank1); end
    if (bus.re !== 0)        begin fails++; $display("FAIL reset_re: got %b required 0", bus.re); end
    if (bus.dqm !== 4'd0)    begin fails++; $display("FAIL reset_dqm: got %h required 0", bus.dqm); end
    if (bus.rd_valid !== 0)  begin fails++; $display("FAIL reset_valid: got %b required 0", bus.rd_valid); end
    if (bus.rd_data !== '0)  begin fails++; $display("FAIL reset_data: got %h required 0", bus.rd_data); end
    if (bus.rd_busy !== 0)   begin fails++; $display("FAIL reset_busy: got %b required 0", bus.rd_busy); end
    if (bus.rd_done !== 0)   begin fails++; $display("FAIL reset_done: got %b required 0", bus.rd_done); end
    xrst = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    int d0;
    d0 = done_cnt;
    clear_stats();
    bus.rd_ready = 1'b1;
    lat_check = 1;
    start_job(20'h00010, 21'd4);
    tests++;
    if (bus.rd_busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b required 1", bus.rd_busy); end
    wait_done(d0, 200, "basic");
    tick(2);
    lat_check = 0;
    tests += 5;
    if (issue_cnt != 4) begin fails++; $display("FAIL basic_issues: got %0d required 4", issue_cnt); end
    if (pop_cnt != 4)   begin fails++; $display("FAIL basic_pops: got %0d required 4", pop_cnt); end
    if (done_cnt != d0 + 1) begin fails++; $display("FAIL basic_done_count: got %0d required %0d", done_cnt - d0, 1); end
    if (done_cyc != last_hs_cyc + 1) begin fails++; $display("FAIL basic_done_cycle: got %0d required %0d", done_cyc, last_hs_cyc + 1); end
    if (bus.rd_busy !== 1'b0) begin fails++; $display("FAIL basic_idle: busy %b required 0", bus.rd_busy); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      m4_addr_t e;
      e = 20'h00010 + m4_addr_t'(i);
      tests++;
      if (addr_log[i] !== e) begin fails++; $display("FAIL basic_addr%0d: got %h required %h", i, addr_log[i], e); end
    end
  endtask

  task automatic test_backpressure();
    int d0;
    d0 = done_cnt;
    clear_stats();
    bus.rd_ready = 1'b0;
    start_job(20'h00200, 21'd16);
    tick(40);
    tests += 3;
    if (issue_cnt != DEPTH) begin fails++; $display("FAIL bp_credit_stop: issues %0d required %0d", issue_cnt, DEPTH); end
    if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_held: got %b required 1", bus.rd_valid); end
    if (pop_cnt != 0) begin fails++; $display("FAIL bp_no_pop: got %0d required 0", pop_cnt); end
    bus.rd_ready = 1'b1;
    wait_done(d0, 400, "bp");
    tick(2);
    tests += 4;
    if (issue_cnt != 16) begin fails++; $display("FAIL bp_issues: got %0d required 16", issue_cnt); end
    if (pop_cnt != 16)   begin fails++; $display("FAIL bp_pops: got %0d required 16", pop_cnt); end
    if (exp_q.size() != 0) begin fails++; $display("FAIL bp_leftover: %0d words undelivered, required 0", exp_q.size()); end
    if (done_cnt != d0 + 1) begin fails++; $display("FAIL bp_done_count: got %0d required 1", done_cnt - d0); end
    for (int i = 0; i < 16 && i < addr_log.size(); i++) begin
      m4_addr_t e;
      e = 20'h00200 + m4_addr_t'(i);
      tests++;
      if (addr_log[i] !== e) begin fails++; $display("FAIL bp_addr%0d: got %h required %h", i, addr_log[i], e); end
    end
  endtask

  task automatic test_bank_wrap();
    m4_addr_t e1 [3];
    m4_addr_t e2 [2];
    int d0;
    e1 = '{20'h7FFFF, 20'h80000, 20'h80001};
    e2 = '{20'hFFFFF, 20'h00000};
    d0 = done_cnt;
    clear_stats();
    start_job(20'h7FFFF, 21'd3);
    wait_done(d0, 200, "wrap1");
    tick(2);
    tests++;
    if (addr_log.size() != 3) begin fails++; $display("FAIL wrap1_count: got %0d required 3", addr_log.size()); end
    for (int i = 0; i < 3 && i < addr_log.size(); i++) begin
      tests++;
      if (addr_log[i] !== e1[i]) begin fails++; $display("FAIL wrap1_addr%0d: got %h required %h", i, addr_log[i], e1[i]); end
    end
    d0 = done_cnt;
    clear_stats();
    start_job(20'hFFFFF, 21'd2);
    wait_done(d0, 200, "wrap2");
    tick(2);
    tests++;
    if (addr_log.size() != 2) begin fails++; $display("FAIL wrap2_count: got %0d required 2", addr_log.size()); end
    for (int i = 0; i < 2 && i < addr_log.size(); i++) begin
      tests++;
      if (addr_log[i] !== e2[i]) begin fails++; $display("FAIL wrap2_addr%0d: got %h required %h", i, addr_log[i], e2[i]); end
    end
  endtask

  task automatic test_slot_gating();
    int d0;
    d0 = done_cnt;
    clear_stats();
    gate_alt = 1;
    start_job(20'h00300, 21'd4);
    wait_done(d0, 300, "gate");
    tick(2);
    gate_alt = 0;
    tests += 2;
    if (issue_cnt != 4) begin fails++; $display("FAIL gate_issues: got %0d required 4", issue_cnt); end
    if (pop_cnt != 4)   begin fails++; $display("FAIL gate_pops: got %0d required 4", pop_cnt); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      m4_addr_t e;
      e = 20'h00300 + m4_addr_t'(i);
      tests++;
      if (addr_log[i] !== e) begin fails++; $display("FAIL gate_addr%0d: got %h required %h", i, addr_log[i], e); end
    end
  endtask

  task automatic test_abort();
    int d0, n, vhigh, iss0;
    d0 = done_cnt;
    clear_stats();
    bus.rd_ready = 1'b0;
    start_job(20'h00040, 21'd16);
    n = 0;
    while (issue_cnt < DEPTH && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (issue_cnt < DEPTH) begin fails++; $display("FAIL abort_setup: issues %0d required %0d", issue_cnt, DEPTH); end
    // Three words sit in the FIFO, the fourth is still in the latency pipe.
    bus.rd_abort = 1'b1;
    tick();
    bus.rd_abort = 1'b0;
    exp_q.delete();
    exp_cyc.delete();
    tests += 2;
    if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b required 0", bus.rd_valid); end
    if (bus.rd_busy !== 1'b0)  begin fails++; $display("FAIL abort_busy: got %b required 0", bus.rd_busy); end
    vhigh = 0;
    iss0 = issue_cnt;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.rd_valid) vhigh++;
    end
    tests += 3;
    if (vhigh != 0) begin fails++; $display("FAIL abort_no_capture: valid high %0d cycles, required 0", vhigh); end
    if (issue_cnt != iss0) begin fails++; $display("FAIL abort_no_issue: %0d extra reads, required 0", issue_cnt - iss0); end
    if (done_cnt != d0) begin fails++; $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt - d0); end
    clear_stats();
    bus.rd_ready = 1'b1;
    start_job(20'h00500, 21'd2);
    wait_done(d0, 200, "abort_restart");
    tick(2);
    tests += 3;
    if (pop_cnt != 2) begin fails++; $display("FAIL restart_pops: got %0d required 2", pop_cnt); end
    if (addr_log.size() != 2 || addr_log[0] !== 20'h00500) begin
      fails++; $display("FAIL restart_addr0: count %0d first %h required 2 / 00500", addr_log.size(), addr_log.size() ? addr_log[0] : '0);
    end
    if (addr_log.size() < 2 || addr_log[1] !== 20'h00501) begin
      fails++; $display("FAIL restart_addr1: required 00501");
    end
  endtask

  task automatic test_edge_starts();
    int d0, t, n;
    // zero length
    d0 = done_cnt;
    clear_stats();
    t = cyc;
    start_job(20'h00123, 21'd0);
    tests++;
    if (bus.rd_busy !== 1'b0) begin fails++; $display("FAIL len0_busy: got %b required 0", bus.rd_busy); end
    tick(8);
    tests += 3;
    if (done_cnt != d0 + 1) begin fails++; $display("FAIL len0_done: got %0d pulses required 1", done_cnt - d0); end
    if (done_cyc != t + 1)  begin fails++; $display("FAIL len0_done_cycle: got %0d required %0d", done_cyc, t + 1); end
    if (issue_cnt != 0)     begin fails++; $display("FAIL len0_no_re: got %0d reads required 0", issue_cnt); end
    // start while busy
    d0 = done_cnt;
    clear_stats();
    start_job(20'h00600, 21'd3);
    tick(2);
    start_job(20'h00700, 21'd5);
    wait_done(d0, 200, "busy_start");
    tick(10);
    tests += 2;
    if (issue_cnt != 3) begin fails++; $display("FAIL busy_start_issues: got %0d required 3", issue_cnt); end
    if (done_cnt != d0 + 1) begin fails++; $display("FAIL busy_start_done: got %0d required 1", done_cnt - d0); end
    for (int i = 0; i < 3 && i < addr_log.size(); i++) begin
      m4_addr_t e;
      e = 20'h00600 + m4_addr_t'(i);
      tests++;
      if (addr_log[i] !== e) begin fails++; $display("FAIL busy_start_addr%0d: got %h required %h", i, addr_log[i], e); end
    end
    // asynchronous reset in the middle of a job
    clear_stats();
    start_job(20'h00800, 21'd8);
    n = 0;
    while (issue_cnt < 2 && n < 100) begin
      tick();
      n++;
    end
    #3;
    xrst = 1'b0;
    #1;
    tests += 7;
    if (bus.rad !== '0)     begin fails++; $display("FAIL xrst_rad: got %h required 0", bus.rad); end
    if (bus.rd_bank1 !== 0) begin fails++; $display("FAIL xrst_bank: got %b required 0", bus.rd_bank1); end
    if (bus.re !== 0)       begin fails++; $display("FAIL xrst_re: got %b required 0", bus.re); end
    if (bus.rd_valid !== 0) begin fails++; $display("FAIL xrst_valid: got %b required 0", bus.rd_valid); end
    if (bus.rd_data !== '0) begin fails++; $display("FAIL xrst_data: got %h required 0", bus.rd_data); end
    if (bus.rd_busy !== 0)  begin fails++; $display("FAIL xrst_busy: got %b required 0", bus.rd_busy); end
    if (bus.rd_done !== 0)  begin fails++; $display("FAIL xrst_done: got %b required 0", bus.rd_done); end
    exp_q.delete();
    exp_cyc.delete();
    tick(2);
    xrst = 1'b1;
    tick(2);
  endtask

  initial begin
    bus.rd_start = 1'b0;
    bus.rd_base  = '0;
    bus.rd_len   = '0;
    bus.rd_abort = 1'b0;
    bus.rd_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_bank_wrap();
    test_slot_gating();
    test_abort();
    test_edge_starts();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
